// File: rtl/mult_pkg.sv
// Shared types and constants for the mult core and the mult_issue wrapper.
package mult_pkg;

    localparam int unsigned A_W              = 8;
    localparam int unsigned Y_W              = 16;
    localparam int unsigned MULT_WORK_CYCLES = 9;
    localparam int unsigned MULT_BUSY_CYCLES = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } issue_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WORK = 2'd1,
        M_WAIT = 2'd2
    } mult_state_t;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [A_W-1:0] b;
    } operands_t;

endpackage

// File: rtl/mult.sv
// 8x8 unsigned shift-add multiplier: 9 WORK cycles plus 1 WAIT cycle per start.
module mult
    import mult_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start_in,
    input  logic [A_W-1:0] a_in,
    input  logic [A_W-1:0] b_in,
    output logic           busy_out,
    output logic [Y_W-1:0] y_out
);
    localparam int unsigned CNT_W = 4;

    mult_state_t      state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [A_W-1:0]   a_q, b_q;
    logic [Y_W-1:0]   acc;

    always_comb begin
        state_d = state;
        case (state)
            M_IDLE:  if (start_in) state_d = M_WORK;
            M_WORK:  if (cnt == CNT_W'(MULT_WORK_CYCLES - 1)) state_d = M_WAIT;
            M_WAIT:  state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    // One partial product per WORK cycle; the final WORK cycle only pads the busy window.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= M_IDLE;
            busy_out <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
        end else begin
            state    <= state_d;
            busy_out <= (state_d != M_IDLE);
            if (state == M_IDLE && start_in) begin
                a_q <= a_in;
                b_q <= b_in;
                acc <= '0;
                cnt <= '0;
            end else if (state == M_WORK) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt < CNT_W'(A_W) && b_q[cnt[2:0]])
                    acc <= acc + (Y_W'(a_q) << cnt);
            end
        end
    end

    assign y_out = acc;

endmodule

// File: rtl/mult_issue.sv
// Tagged operand FIFO in front of the sequential mult core, with a held valid/ready result port.
module mult_issue
    import mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [A_W-1:0]   a_in,
    input  logic [A_W-1:0]   b_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [Y_W-1:0]   y_out,
    output logic [TAG_W-1:0] tag_out
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    issue_state_t     state, state_d;
    operands_t        op_mem  [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] tag_q;
    logic             push, start, capture, retire, fifo_empty;
    logic             mult_busy;
    logic [Y_W-1:0]   mult_y;

    // Ready looks only at the registered count, so a same-cycle pop never frees a full slot.
    assign in_ready_out = (count != CNT_W'(DEPTH));
    assign push         = in_valid_in && in_ready_out;
    assign fifo_empty   = (count == '0);

    always_comb begin
        state_d = state;
        start   = 1'b0;
        capture = 1'b0;
        retire  = 1'b0;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: begin
                start   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: if (!mult_busy) begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: if (out_ready_in) begin
                retire  = 1'b1;
                state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tag_q         <= '0;
            out_valid_out <= 1'b0;
            y_out         <= '0;
            tag_out       <= '0;
        end else begin
            state <= state_d;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (start) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                tag_q  <= tag_mem[rd_ptr];
            end
            case ({push, start})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (capture) begin
                y_out         <= mult_y;
                tag_out       <= tag_q;
                out_valid_out <= 1'b1;
            end else if (retire) begin
                out_valid_out <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk_in) begin
        if (push) begin
            op_mem[wr_ptr]  <= '{a: a_in, b: b_in};
            tag_mem[wr_ptr] <= tag_in;
        end
    end

    mult u_mult (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (start),
        .a_in     (op_mem[rd_ptr].a),
        .b_in     (op_mem[rd_ptr].b),
        .busy_out (mult_busy),
        .y_out    (mult_y)
    );

endmodule
